muxn_rr_stage: RTL and testbench
================================

Name: muxn_rr_stage

Overview:
- Parametrised N-channel successor to the 2:1 interface mux.
- Selects one of N_CH valid/ready input channels per cycle, either by fixed external select or by round-robin arbitration.
- Registers the winning word into a one-entry output stage with valid/ready backpressure.
- Sits between multiple interface masters and a single downstream consumer.

Parameters:
- DATA_WITH, 8, width of each channel's data word (codebase spelling).
- N_CH, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(N_CH), channel-index width (derived; not to be overridden).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_data  in  N_CH*DATA_WITH  flattened channel data; channel k occupies [k*DATA_WITH +: DATA_WITH].
- i_valid  in  N_CH  per-channel valid.
- o_ready  out  N_CH  per-channel ready; combinational, one-hot or zero.
- i_mode  in  1  0 = fixed select, 1 = round-robin.
- i_sel  in  SEL_W  channel index used in fixed mode.
- o_data  out  DATA_WITH  registered selected data.
- o_ch  out  SEL_W  index of the channel that produced o_data.
- o_valid  out  1  output stage holds a word.
- i_ready  in  1  downstream accepts o_data.

Behaviour:
- Reset (async assert, sync release): o_valid=0, o_data=0, o_ch=0, RR pointer=0. o_ready is all-zero while i_rst_n=0.
- can_accept = !o_valid | i_ready. A full output stage drained in the same cycle still accepts a new word, giving 1 word/cycle throughput.
- Transfer on channel k: i_valid[k] & o_ready[k]. At most one transfer per cycle.
- Fixed mode: o_ready[k] = can_accept & (k == i_sel). i_valid does not gate o_ready.
  - If i_sel >= N_CH (non-power-of-two N_CH), o_ready=0 and nothing is accepted.
- RR mode: grant the first channel with i_valid=1, searching from ptr upward with wrap modulo N_CH. o_ready[grant] = can_accept.
  - With no valids, o_ready=0.
  - ptr <= (grant+1) mod N_CH only on an accepted transfer. It wraps from N_CH-1 to 0.
- Fixed mode leaves ptr unchanged.
- On transfer: o_data <= channel data, o_ch <= channel index, o_valid <= 1. Latency: 1 cycle from accept to o_valid.
- No transfer and i_ready=1: o_valid <= 0. o_data and o_ch hold their stale values.
- o_valid=1 and i_ready=0: o_data, o_ch and o_valid hold stable.
- Mode or i_sel change: takes effect on the same cycle's o_ready and never disturbs the held output word.
- Upstream rule: once i_valid[k]=1 it must stay high with stable data until accepted. The block need not check this; the bench asserts it.
- Reset mid-transfer: the word in the output stage is discarded and o_valid drops immediately (asynchronously).

Decomposition:
- Package muxn_pkg holds:
  - typedef enum logic {MODE_FIXED=1'b0, MODE_RR=1'b1} mux_mode_e
  - function rr_pick(valid, ptr) returning grant index and a found flag, shared with the bench model.
- One sub-module, rr_arbiter: params N_CH; ports i_clk, i_rst_n, i_req[N_CH], i_adv, o_gnt[N_CH], o_gnt_idx. It owns ptr.
- muxn_rr_stage owns the mode muxing, the datapath mux and the output register.

Test Plan:
- Reset: assert i_rst_n=0 while o_valid=1 and i_ready=0 -> o_valid=0, o_data=0, o_ch=0 immediately; after release, first RR grant is channel 0.
- Fixed mode, N_CH=4, i_sel=2, i_valid=4'b1111, ch2 data=8'hA5, i_ready=1 -> o_ready=4'b0100; next cycle o_data=8'hA5, o_ch=2, o_valid=1.
- RR fairness: all 4 valid, i_ready=1, 8 cycles -> o_ch sequence 0,1,2,3,0,1,2,3 (wrap checked). With i_valid=4'b1010 -> 1,3,1,3.
- Backpressure: o_valid=1, i_ready=0 for 3 cycles -> o_ready=0, o_data/o_ch stable, ptr unchanged. i_ready=1 with ch1 valid -> accept the same cycle, new word next cycle, no bubble.
- Mode switch: RR ptr=3, switch to fixed with i_sel=0 -> grant ch0. Switch back to RR -> next grant is ch3 (ptr preserved).
- N_CH=3, fixed mode, i_sel=3 with i_valid=3'b111 -> o_ready=0 forever; o_valid drains to 0 after one cycle with i_ready=1.

Source files
------------

// File: rtl/muxn_pkg.sv
// Shared types and the round-robin search used by the N-channel mux stage.
package muxn_pkg;

    localparam int MAX_CH    = 16;
    localparam int MAX_SEL_W = 4;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    typedef struct packed {
        logic                 found;
        logic [MAX_SEL_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid at or above ptr, wrapping modulo n_ch.
    // Walks offsets high to low so the smallest offset is the last write.
    function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0]    valid,
                                         input logic [MAX_SEL_W-1:0] ptr,
                                         input int                   n_ch);
        rr_pick_t r;
        int       cand;
        r = '0;
        for (int off = MAX_CH - 1; off >= 0; off--) begin
            if (off < n_ch) begin
                cand = (int'(ptr) + off) % n_ch;
                if (valid[cand[MAX_SEL_W-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = MAX_SEL_W'(cand);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: owns the rotating priority pointer, advances past the
// granted channel only when the caller reports an accepted transfer.
module rr_arbiter
    import muxn_pkg::*;
#(
    parameter  int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_CH-1:0]  i_req,
    input  logic             i_adv,
    output logic [N_CH-1:0]  o_gnt,
    output logic [SEL_W-1:0] o_gnt_idx
);

    logic [SEL_W-1:0] ptr;
    rr_pick_t         pick;

    always_comb begin
        pick      = rr_pick(MAX_CH'(i_req), MAX_SEL_W'(ptr), N_CH);
        o_gnt_idx = SEL_W'(pick.idx);
        o_gnt     = '0;
        for (int k = 0; k < N_CH; k++) begin
            o_gnt[k] = pick.found && (pick.idx == MAX_SEL_W'(k));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr <= '0;
        end else if (i_adv) begin
            ptr <= (o_gnt_idx == SEL_W'(N_CH - 1)) ? '0 : o_gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/muxn_rr_stage.sv
// N-channel valid/ready mux with fixed or round-robin selection feeding a
// one-entry registered output stage.
module muxn_rr_stage
    import muxn_pkg::*;
#(
    parameter  int DATA_WITH = 8,
    parameter  int N_CH      = 4,
    localparam int SEL_W     = $clog2(N_CH)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_CH*DATA_WITH-1:0] i_data,
    input  logic [N_CH-1:0]           i_valid,
    output logic [N_CH-1:0]           o_ready,
    input  logic                      i_mode,
    input  logic [SEL_W-1:0]          i_sel,
    output logic [DATA_WITH-1:0]      o_data,
    output logic [SEL_W-1:0]          o_ch,
    output logic                      o_valid,
    input  logic                      i_ready
);

    logic                 mode_rr;
    logic                 can_accept;
    logic                 xfer;
    logic [N_CH-1:0]      rr_gnt;
    logic [SEL_W-1:0]     rr_gnt_idx;
    logic [DATA_WITH-1:0] win_data;
    logic [SEL_W-1:0]     win_ch;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (i_valid),
        .i_adv     (mode_rr && xfer),
        .o_gnt     (rr_gnt),
        .o_gnt_idx (rr_gnt_idx)
    );

    // An out-of-range i_sel matches no channel, so nothing is ever accepted.
    always_comb begin
        mode_rr    = (mux_mode_e'(i_mode) == MODE_RR);
        can_accept = i_rst_n && (!o_valid || i_ready);
        o_ready    = '0;
        win_data   = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (mode_rr) begin
                o_ready[k] = can_accept && rr_gnt[k];
            end else begin
                o_ready[k] = can_accept && (i_sel == SEL_W'(k));
            end
            if (o_ready[k]) begin
                win_data = i_data[k*DATA_WITH +: DATA_WITH];
            end
        end
        win_ch = mode_rr ? rr_gnt_idx : i_sel;
        xfer   = |(i_valid & o_ready);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_ch    <= '0;
        end else if (xfer) begin
            o_valid <= 1'b1;
            o_data  <= win_data;
            o_ch    <= win_ch;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_muxn_rr_stage.sv
// Directed bench for muxn_rr_stage (N_CH=4 main instance, N_CH=3 for the
// out-of-range fixed-select case).
module tb_muxn_rr_stage;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] i_data;
    logic [3:0]  i_valid;
    logic [3:0]  o_ready;
    logic        i_mode;
    logic [1:0]  i_sel;
    logic [7:0]  o_data;
    logic [1:0]  o_ch;
    logic        o_valid;
    logic        i_ready;

    logic [23:0] d3_data;
    logic [2:0]  d3_valid;
    logic [2:0]  d3_oready;
    logic        d3_mode;
    logic [1:0]  d3_sel;
    logic [7:0]  d3_odata;
    logic [1:0]  d3_och;
    logic        d3_ovalid;
    logic        d3_iready;

    int checks   = 0;
    int failures = 0;

    logic        up_en = 1'b0;
    logic [3:0]  prev_valid = '0;
    logic [3:0]  prev_acc = '0;
    logic [31:0] prev_data = '0;

    logic [7:0]  ch_data [4] = '{8'h10, 8'h11, 8'hA5, 8'h13};
    logic [1:0]  rr_alt  [4] = '{2'd1, 2'd3, 2'd1, 2'd3};

    always #5 clk = ~clk;

    muxn_rr_stage #(.DATA_WITH(8), .N_CH(4)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_mode  (i_mode),
        .i_sel   (i_sel),
        .o_data  (o_data),
        .o_ch    (o_ch),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    muxn_rr_stage #(.DATA_WITH(8), .N_CH(3)) u_dut3 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data  (d3_data),
        .i_valid (d3_valid),
        .o_ready (d3_oready),
        .i_mode  (d3_mode),
        .i_sel   (d3_sel),
        .o_data  (d3_odata),
        .o_ch    (d3_och),
        .o_valid (d3_ovalid),
        .i_ready (d3_iready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // A pending, unaccepted request must stay asserted with stable data.
    always @(posedge clk) begin
        if (up_en) begin
            for (int k = 0; k < 4; k++) begin
                if (prev_valid[k] && !prev_acc[k]) begin
                    assert (i_valid[k] && (i_data[k*8 +: 8] === prev_data[k*8 +: 8])) else begin
                        failures++;
                        $error("FAIL upstream_hold ch=%0d valid=%0b", k, i_valid[k]);
                    end
                end
            end
        end
        prev_valid = i_valid;
        prev_acc   = i_valid & o_ready;
        prev_data  = i_data;
    end

    initial begin
        rst_n     = 1'b0;
        i_data    = {8'h13, 8'hA5, 8'h11, 8'h10};
        i_valid   = 4'b1111;
        i_mode    = 1'b1;
        i_sel     = 2'd0;
        i_ready   = 1'b0;
        d3_data   = {8'h32, 8'h31, 8'h30};
        d3_valid  = 3'b000;
        d3_mode   = 1'b0;
        d3_sel    = 2'd0;
        d3_iready = 1'b1;

        #3;
        chk("reset_o_ready", 32'(o_ready), 32'h0);
        chk("reset_o_valid", 32'(o_valid), 32'h0);
        chk("reset_o_data",  32'(o_data),  32'h0);
        chk("reset_o_ch",    32'(o_ch),    32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // fixed select, channel 2
        i_mode  = 1'b0;
        i_sel   = 2'd2;
        i_valid = 4'b1111;
        i_ready = 1'b1;
        #1 chk("fixed_o_ready", 32'(o_ready), 32'h4);
        cyc();
        chk("fixed_o_data",  32'(o_data),  32'hA5);
        chk("fixed_o_ch",    32'(o_ch),    32'h2);
        chk("fixed_o_valid", 32'(o_valid), 32'h1);

        // round robin, all channels requesting
        i_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1 chk("rr_all_o_ready", 32'(o_ready), 32'(1 << (i % 4)));
            cyc();
            chk("rr_all_o_ch",   32'(o_ch),   32'(i % 4));
            chk("rr_all_o_data", 32'(o_data), 32'(ch_data[i % 4]));
        end

        i_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rr_alt_o_ch", 32'(o_ch), 32'(rr_alt[i]));
        end

        // backpressure with ch3 word held
        i_ready = 1'b0;
        i_valid = 4'b0010;
        up_en   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_o_ready", 32'(o_ready), 32'h0);
            cyc();
            chk("bp_o_data",  32'(o_data),  32'h13);
            chk("bp_o_ch",    32'(o_ch),    32'h3);
            chk("bp_o_valid", 32'(o_valid), 32'h1);
        end
        i_ready = 1'b1;
        #1 chk("bp_release_o_ready", 32'(o_ready), 32'h2);
        cyc();
        chk("bp_release_o_ch",    32'(o_ch),    32'h1);
        chk("bp_release_o_data",  32'(o_data),  32'h11);
        chk("bp_release_o_valid", 32'(o_valid), 32'h1);

        // walk ptr to 3, then mode switch
        i_valid = 4'b0100;
        #1 chk("ptr_walk_o_ready", 32'(o_ready), 32'h4);
        cyc();
        chk("ptr_walk_o_ch", 32'(o_ch), 32'h2);

        i_mode  = 1'b0;
        i_sel   = 2'd0;
        i_valid = 4'b1001;
        #1 chk("sw_fixed_o_ready", 32'(o_ready), 32'h1);
        cyc();
        chk("sw_fixed_o_ch",   32'(o_ch),   32'h0);
        chk("sw_fixed_o_data", 32'(o_data), 32'h10);

        i_mode = 1'b1;
        #1 chk("sw_rr_o_ready", 32'(o_ready), 32'h8);
        cyc();
        chk("sw_rr_o_ch", 32'(o_ch), 32'h3);

        // drain: no requests, stale word fields held
        up_en   = 1'b0;
        i_valid = 4'b0000;
        #1 chk("drain_o_ready", 32'(o_ready), 32'h0);
        cyc();
        chk("drain_o_valid", 32'(o_valid), 32'h0);
        chk("drain_o_data",  32'(o_data),  32'h13);
        chk("drain_o_ch",    32'(o_ch),    32'h3);

        // reset while a word is stalled
        i_valid = 4'b0001;
        cyc();
        chk("pre_rst_o_valid", 32'(o_valid), 32'h1);
        chk("pre_rst_o_ch",    32'(o_ch),    32'h0);
        i_ready = 1'b0;
        i_valid = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_o_valid", 32'(o_valid), 32'h0);
        chk("mid_rst_o_data",  32'(o_data),  32'h0);
        chk("mid_rst_o_ch",    32'(o_ch),    32'h0);
        cyc();
        rst_n   = 1'b1;
        i_mode  = 1'b1;
        i_valid = 4'b1111;
        i_ready = 1'b1;
        #1 chk("post_rst_o_ready", 32'(o_ready), 32'h1);
        cyc();
        chk("post_rst_o_ch", 32'(o_ch), 32'h0);
        i_valid = 4'b0000;

        // N_CH=3: out-of-range fixed select
        d3_mode  = 1'b0;
        d3_sel   = 2'd1;
        d3_valid = 3'b111;
        #1 chk("n3_sel1_o_ready", 32'(d3_oready), 32'h2);
        cyc();
        chk("n3_sel1_o_valid", 32'(d3_ovalid), 32'h1);
        chk("n3_sel1_o_data",  32'(d3_odata),  32'h31);
        d3_sel = 2'd3;
        #1 chk("n3_sel3_o_ready", 32'(d3_oready), 32'h0);
        cyc();
        chk("n3_sel3_o_valid", 32'(d3_ovalid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("n3_sel3_hold_o_ready", 32'(d3_oready), 32'h0);
            chk("n3_sel3_hold_o_valid", 32'(d3_ovalid), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
